// File: rtl/core_run_controller.sv
// Run/debug sequencer: owns the instruction-memory write port while loading, then gates the core
// through a clock enable and a core reset (run, halt, single-step, PC breakpoint).
module core_run_controller #(
  parameter int                    DATA_WIDTH    = 20,
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    MEM_SIZE      = 256,
  parameter int                    CNT_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR    = 20'hFFFFF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     step_i,
  input  logic                     halt_req_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0]    load_data_i,
  input  logic                     load_done_i,
  input  logic                     bp_enable_i,
  input  logic [ADDRESS_WIDTH-1:0] bp_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0]    instruction_i,
  output logic                     core_en_o,
  output logic                     core_rst_n_o,
  output logic                     imem_we_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0]    imem_wdata_o,
  output logic [2:0]               state_o,
  output logic                     done_o,
  output logic                     load_err_o,
  output logic [CNT_WIDTH-1:0]     instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CRST   = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_HALTED = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e                   state_q, state_d;
  logic                     imem_we_q, imem_we_d;
  logic [ADDRESS_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;
  logic                     load_err_q, load_err_d;
  logic                     done_q, done_d;
  logic [CNT_WIDTH-1:0]     instr_count_q, instr_count_d;
  logic                     crst_cnt_q, crst_cnt_d;
  logic                     bp_skip_q, bp_skip_d;

  logic core_en;
  logic load_ready;
  logic is_halt;
  logic bp_hit;
  logic addr_ok;

  assign is_halt = (instruction_i == HALT_INSTR);
  assign bp_hit  = bp_enable_i && (pc_i == bp_addr_i);
  assign addr_ok = ({{(32-ADDRESS_WIDTH){1'b0}}, load_addr_i} < 32'(MEM_SIZE));

  always_comb begin
    state_d      = state_q;
    core_en      = 1'b0;
    load_ready   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    load_err_d   = load_err_q;
    done_d       = done_q;
    crst_cnt_d   = 1'b0;
    bp_skip_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_valid_i) begin
          state_d    = S_LOAD;
          load_err_d = 1'b0;
        end else if (start_i) begin
          state_d = S_CRST;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid_i) begin
          if (addr_ok) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = load_addr_i;
            imem_wdata_d = load_data_i;
          end else begin
            load_err_d = 1'b1;
          end
        end
        if (load_done_i) state_d = S_IDLE;
      end
      S_CRST: begin
        done_d = 1'b0;
        if (crst_cnt_q) state_d = S_RUN;
        else            crst_cnt_d = 1'b1;
      end
      S_RUN: begin
        // Stop checks gate core_en in the same cycle so the stopping instruction never commits.
        if (is_halt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (halt_req_i) begin
          state_d = S_HALTED;
        end else if (bp_hit && !bp_skip_q) begin
          state_d = S_HALTED;
        end else begin
          core_en = 1'b1;
        end
      end
      S_HALTED: begin
        if (start_i) begin
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end else if (step_i) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (is_halt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          core_en = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_DONE: begin
        if (load_valid_i) begin
          state_d    = S_LOAD;
          load_err_d = 1'b0;
        end else if (start_i) begin
          state_d = S_CRST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == S_CRST)                 instr_count_d = '0;
    else if (core_en && !(&instr_count_q)) instr_count_d = instr_count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      load_err_q    <= 1'b0;
      done_q        <= 1'b0;
      instr_count_q <= '0;
      crst_cnt_q    <= 1'b0;
      bp_skip_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      load_err_q    <= load_err_d;
      done_q        <= done_d;
      instr_count_q <= instr_count_d;
      crst_cnt_q    <= crst_cnt_d;
      bp_skip_q     <= bp_skip_d;
    end
  end

  assign load_ready_o  = load_ready;
  assign core_en_o     = core_en;
  assign core_rst_n_o  = rst_n_i && (state_q != S_CRST);
  assign imem_we_o     = imem_we_q;
  assign imem_addr_o   = imem_addr_q;
  assign imem_wdata_o  = imem_wdata_q;
  assign state_o       = state_q;
  assign done_o        = done_q;
  assign load_err_o    = load_err_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench: a tiny core model (PC + instruction memory fed by imem writes) driven by the controller.
module tb_core_run_controller;
  localparam int DW = 20;
  localparam int AW = 8;
  localparam int MS = 200;
  localparam int CW = 32;
  localparam logic [DW-1:0] HALT = 20'hFFFFF;

  logic          clk, rst_n;
  logic          start, step, halt_req, load_valid, load_ready, load_done;
  logic [AW-1:0] load_addr, bp_addr, pc, imem_addr;
  logic [DW-1:0] load_data, instruction, imem_wdata;
  logic          bp_enable, core_en, core_rst_n, imem_we, done, load_err;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  logic [DW-1:0] mem [256];
  int tests_run = 0;
  int fail_count = 0;

  core_run_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS), .CNT_WIDTH(CW), .HALT_INSTR(HALT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .step_i(step), .halt_req_i(halt_req),
    .load_valid_i(load_valid), .load_ready_o(load_ready), .load_addr_i(load_addr),
    .load_data_i(load_data), .load_done_i(load_done), .bp_enable_i(bp_enable),
    .bp_addr_i(bp_addr), .pc_i(pc), .instruction_i(instruction), .core_en_o(core_en),
    .core_rst_n_o(core_rst_n), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .state_o(state), .done_o(done), .load_err_o(load_err),
    .instr_count_o(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PC advances only when enabled, cleared by the core reset.
  always @(posedge clk) begin
    if (!core_rst_n)  pc <= '0;
    else if (core_en) pc <= pc + 1'b1;
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end
  assign instruction = mem[pc];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit last, input bit expect_we);
    load_valid = 1'b1; load_addr = a; load_data = d; load_done = last;
    tick();
    check("imem_we", {63'd0, imem_we}, {63'd0, expect_we});
    if (expect_we) begin
      check("imem_addr", 64'(imem_addr), 64'(a));
      check("imem_wdata", 64'(imem_wdata), 64'(d));
    end
    load_valid = 1'b0; load_done = 1'b0;
    tick();
    check("imem_we_one_cycle", {63'd0, imem_we}, 64'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    pc = '0;
    start = 0; step = 0; halt_req = 0; load_valid = 0; load_done = 0;
    load_addr = '0; load_data = '0; bp_enable = 0; bp_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", 64'(state), 64'd0);
    check("rst_core_en", {63'd0, core_en}, 64'd0);
    check("rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("rst_imem_we", {63'd0, imem_we}, 64'd0);
    check("rst_load_ready", {63'd0, load_ready}, 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_done_err", {62'd0, done, load_err}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("core_rst_n_released", {63'd0, core_rst_n}, 64'd1);

    // Program load: 0:A 1:B 2:HALT
    load_valid = 1'b1; load_addr = 8'd0; load_data = 20'h12345;
    tick();
    check("load_state", 64'(state), 64'd1);
    check("load_ready", {63'd0, load_ready}, 64'd1);
    load_word(8'd0, 20'h12345, 1'b0, 1'b1);
    load_word(8'd1, 20'h0ABCD, 1'b0, 1'b1);
    load_word(8'd2, HALT, 1'b1, 1'b1);
    check("load_done_idle", 64'(state), 64'd0);

    // Run to HALT at pc=2
    start = 1'b1;
    tick();
    start = 1'b0;
    check("crst_state", 64'(state), 64'd2);
    check("crst_rst_n_c1", {63'd0, core_rst_n}, 64'd0);
    tick();
    check("crst_rst_n_c2", {63'd0, core_rst_n}, 64'd0);
    tick();
    check("run_state", 64'(state), 64'd3);
    check("run_rst_n", {63'd0, core_rst_n}, 64'd1);
    check("run_core_en", {63'd0, core_en}, 64'd1);
    check("run_pc0", 64'(pc), 64'd0);
    tick();
    tick();
    check("halt_pc", 64'(pc), 64'd2);
    check("halt_gate", {63'd0, core_en}, 64'd0);
    tick();
    check("done_state", 64'(state), 64'd6);
    check("done_flag", {63'd0, done}, 64'd1);
    check("done_count", 64'(instr_count), 64'd2);

    // Reload from DONE: overwrite 2, out-of-range word, HALT at 9
    load_valid = 1'b1; load_addr = 8'd2; load_data = 20'h0C0C0;
    tick();
    check("reload_state", 64'(state), 64'd1);
    load_word(8'd2, 20'h0C0C0, 1'b0, 1'b1);
    load_word(8'(MS), 20'h55555, 1'b0, 1'b0);
    check("load_err_set", {63'd0, load_err}, 64'd1);
    load_word(8'd9, HALT, 1'b1, 1'b1);
    check("load_err_sticky", {63'd0, load_err}, 64'd1);
    check("oob_not_written", 64'(mem[MS]), 64'd0);

    // Breakpoint at 5
    bp_enable = 1'b1; bp_addr = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state !== 3'd5 && n < 40) begin
      tick();
      n++;
    end
    check("bp_halted", 64'(state), 64'd5);
    check("bp_pc", 64'(pc), 64'd5);
    check("bp_count", 64'(instr_count), 64'd5);
    check("bp_core_en", {63'd0, core_en}, 64'd0);
    check("bp_done_cleared", {63'd0, done}, 64'd0);

    // Resume past the breakpoint, then halt_req at pc 6
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", 64'(state), 64'd3);
    check("resume_core_en", {63'd0, core_en}, 64'd1);
    tick();
    check("resume_pc", 64'(pc), 64'd6);
    halt_req = 1'b1;
    #1;
    check("halt_req_gate", {63'd0, core_en}, 64'd0);
    tick();
    halt_req = 1'b0;
    check("halt_req_state", 64'(state), 64'd5);
    check("halt_req_count", 64'(instr_count), 64'd6);

    // Three single steps
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_state", 64'(state), 64'd4);
      check("step_core_en", {63'd0, core_en}, 64'd1);
      tick();
      check("step_back_halted", 64'(state), 64'd5);
      check("step_core_en_off", {63'd0, core_en}, 64'd0);
      check("step_count", 64'(instr_count), 64'(7 + i));
    end

    // Stepping onto HALT goes to DONE without executing it
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_halt_gate", {63'd0, core_en}, 64'd0);
    tick();
    check("step_done_state", 64'(state), 64'd6);
    check("step_done_pc", 64'(pc), 64'd9);
    check("step_done_count", 64'(instr_count), 64'd9);

    // LOAD entry clears load_err
    load_valid = 1'b1; load_addr = 8'd3; load_data = 20'h00777;
    tick();
    check("load_err_cleared", {63'd0, load_err}, 64'd0);
    load_word(8'd3, 20'h00777, 1'b1, 1'b1);

    // Reset mid-RUN
    bp_enable = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midrun_state", 64'(state), 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_state", 64'(state), 64'd0);
    check("midrun_rst_core_en", {63'd0, core_en}, 64'd0);
    check("midrun_rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("midrun_rst_count", 64'(instr_count), 64'd0);
    tick();
    rst_n = 1'b1;

    // Reset mid-LOAD drops the pending write
    load_valid = 1'b1; load_addr = 8'd4; load_data = 20'h0BEEF;
    tick();
    tick();
    check("midload_we", {63'd0, imem_we}, 64'd1);
    rst_n = 1'b0;
    load_valid = 1'b0;
    #1;
    check("midload_rst_we", {63'd0, imem_we}, 64'd0);
    check("midload_rst_state", 64'(state), 64'd0);
    check("midload_rst_ready", {63'd0, load_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end
endmodule
